// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl: initiator-side controller for the 2x2 matmul core.
// Collects one 8-element operand frame (A then B, row-major), pulses
// core_start, waits for core_done, captures C and streams 4 results out.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid && ready are both high. Once a producer raises valid it holds
// data/last stable until the transfer; ready may depend on state only, never
// on valid, so there is no combinational valid->ready path.
module matmul_stream_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [ACC_W-1:0]    m_data,
    output logic                m_last,
    output logic                core_start,
    output logic [4*DATA_W-1:0] core_A,
    output logic [4*DATA_W-1:0] core_B,
    input  logic [4*ACC_W-1:0]  core_C,
    input  logic                core_done,
    output logic                busy,
    output logic                err_frame,
    output logic                err_timeout,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [1:0]          ridx_q, ridx_d;
    logic [4*DATA_W-1:0] core_a_q, core_a_d;
    logic [4*DATA_W-1:0] core_b_q, core_b_d;
    logic [4*ACC_W-1:0]  c_q, c_d;
    logic                err_frame_q, err_frame_d;
    logic                err_timeout_q, err_timeout_d;

    // Next-state logic for the LOAD -> START -> WAIT -> DRAIN sequence.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        ridx_d        = ridx_q;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        c_d           = c_q;
        err_frame_d   = err_frame_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_LOAD: begin
                if (s_valid) begin
                    if (idx_q[2]) core_b_d[int'(idx_q[1:0])*DATA_W +: DATA_W] = s_data;
                    else          core_a_d[int'(idx_q[1:0])*DATA_W +: DATA_W] = s_data;
                    // s_last must mark exactly the 8th beat; anything else drops the frame
                    if (s_last != (idx_q == 3'd7)) begin
                        err_frame_d = 1'b1;
                        idx_d       = 3'd0;
                    end else if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    c_d     = core_C;
                    ridx_d  = 2'd0;
                    state_d = S_DRAIN;
                end else if (tcnt_q == T_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_LOAD;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    if (ridx_q == 2'd3) begin
                        ridx_d  = 2'd0;
                        state_d = S_LOAD;
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            tcnt_q        <= '0;
            ridx_q        <= '0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            c_q           <= '0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            ridx_q        <= ridx_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            c_q           <= c_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // s_ready is gated by rst so it stays low while reset is held.
    assign s_ready     = (state_q == S_LOAD) && !rst;
    assign m_valid     = (state_q == S_DRAIN);
    assign m_data      = m_valid ? c_q[int'(ridx_q)*ACC_W +: ACC_W] : '0;
    assign m_last      = m_valid && (ridx_q == 2'd3);
    assign core_start  = (state_q == S_START);
    assign core_A      = core_a_q;
    assign core_B      = core_b_q;
    assign busy        = (state_q != S_LOAD);
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed testbench for matmul_stream_ctrl with a behavioural 2x2 core.
module tb_matmul_stream_ctrl;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int TO_CYC = 16;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid, s_ready, s_last;
    logic [DATA_W-1:0]   s_data;
    logic                m_valid, m_ready, m_last;
    logic [ACC_W-1:0]    m_data;
    logic                core_start, core_done;
    logic [4*DATA_W-1:0] core_A, core_B;
    logic [4*ACC_W-1:0]  core_C;
    logic                busy, err_frame, err_timeout;
    logic [1:0]          dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [ACC_W-1:0] exp_q[$];

    bit core_en    = 1'b1;
    int manual_req = 0;
    int start_cnt  = 0;
    int mv_cnt     = 0;
    int viol_cnt   = 0;

    matmul_stream_ctrl #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_A(core_A), .core_B(core_B),
        .core_C(core_C), .core_done(core_done),
        .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: start pulses, result beats, s_ready while busy
    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
        if (m_valid === 1'b1) mv_cnt++;
        if (busy === 1'b1 && s_ready === 1'b1) viol_cnt++;
    end

    function automatic logic signed [31:0] el(input logic [4*DATA_W-1:0] m, input int i, input int j);
        logic signed [DATA_W-1:0] t;
        logic signed [31:0] r;
        t = m[(2*i+j)*DATA_W +: DATA_W];
        r = t;
        return r;
    endfunction

    function automatic logic [4*ACC_W-1:0] matmul(input logic [4*DATA_W-1:0] a, input logic [4*DATA_W-1:0] b);
        logic [4*ACC_W-1:0] res;
        res = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                res[(2*i+j)*ACC_W +: ACC_W] = el(a, i, 0) * el(b, 0, j) + el(a, i, 1) * el(b, 1, j);
        return res;
    endfunction

    // Core model: done 3 cycles after start, or a manual stray pulse on request
    initial begin : core_model
        int manual_ack;
        manual_ack = 0;
        core_done  = 1'b0;
        core_C     = '0;
        forever begin
            @(negedge clk);
            if (manual_req != manual_ack) begin
                manual_ack = manual_req;
                core_C     = {4{32'h0BAD0BAD}};
                core_done  = 1'b1;
                @(negedge clk);
                core_done  = 1'b0;
            end else if (core_start === 1'b1 && core_en) begin
                repeat (3) @(negedge clk);
                core_C    = matmul(core_A, core_B);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    // Driver: one input beat; returns at the negedge after the handshake
    task automatic send_beat(input logic [7:0] d, input logic last, input int gap);
        int cnt;
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        cnt = 0;
        while (s_ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) begin
            checks++; failures++;
            $display("FAIL send_beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f, input int max_gap);
        for (int i = 0; i < 8; i++)
            send_beat(f[i*8 +: 8], (i == 7), $urandom_range(0, max_gap));
    endtask

    // Scoreboard drain: pops exp_q, optional stall of `stall` cycles per beat
    task automatic recv_results(input int stall);
        int cnt;
        logic [ACC_W-1:0] exp;
        logic exp_last;
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            while (m_valid !== 1'b1 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt >= 100) begin
                failures++;
                $display("FAIL recv_wait beat %0d: m_valid=%b required 1", r, m_valid);
                return;
            end
            exp      = exp_q.pop_front();
            exp_last = (r == 3);
            for (int k = 0; k < stall; k++) begin
                checks++;
                if (m_data !== exp || m_last !== exp_last || m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold beat %0d cyc %0d: data=%0d last=%b valid=%b required data=%0d last=%b valid=1",
                             r, k, $signed(m_data), m_last, m_valid, $signed(exp), exp_last);
                end
                @(negedge clk);
            end
            m_ready = 1'b1;
            checks++;
            if (m_data !== exp) begin
                failures++;
                $display("FAIL m_data beat %0d: got %0d required %0d", r, $signed(m_data), $signed(exp));
            end
            checks++;
            if (m_last !== exp_last) begin
                failures++;
                $display("FAIL m_last beat %0d: got %b required %b", r, m_last, exp_last);
            end
            @(negedge clk);
            m_ready = 1'b0;
        end
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== S_LOAD) begin
            failures++;
            $display("FAIL after_drain: m_valid=%b busy=%b state=%0d required 0 0 0", m_valid, busy, dbg_state);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({s_ready, m_valid, m_last, core_start, busy, err_frame, err_timeout} !== 7'b0 ||
            m_data !== '0 || core_A !== '0 || core_B !== '0 || dbg_state !== S_LOAD) begin
            failures++;
            $display("FAIL %s: rdy=%b mv=%b ml=%b md=%h st=%b busy=%b ef=%b et=%b A=%h B=%h state=%0d required all 0",
                     tag, s_ready, m_valid, m_last, m_data, core_start, busy, err_frame, err_timeout,
                     core_A, core_B, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: s_ready=%b busy=%b required 1 0", s_ready, busy);
        end
    endtask

    task automatic test_basic();
        int s0;
        s0 = start_cnt;
        send_frame(64'h0807060504030201, 0);
        checks++;
        if (core_start !== 1'b1 || dbg_state !== S_START || s_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_start_latency: start=%b state=%0d rdy=%b busy=%b required 1 1 0 1",
                     core_start, dbg_state, s_ready, busy);
        end
        checks++;
        if (core_A !== 32'h04030201 || core_B !== 32'h08070605) begin
            failures++;
            $display("FAIL basic_operands: A=%h B=%h required 04030201 08070605", core_A, core_B);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || dbg_state !== S_WAIT || core_A !== 32'h04030201) begin
            failures++;
            $display("FAIL basic_wait: m_valid=%b state=%0d A=%h required 0 2 04030201", m_valid, dbg_state, core_A);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_done_latency: m_valid=%b required 1", m_valid);
        end
        exp_q.push_back(32'd19); exp_q.push_back(32'd22);
        exp_q.push_back(32'd43); exp_q.push_back(32'd50);
        recv_results(0);
        checks++;
        if (start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL basic_start_count: got %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_signed();
        send_frame(64'h0807FA05FC0302FF, 0);
        exp_q.push_back(32'd9);   exp_q.push_back(32'd22);
        exp_q.push_back(-32'sd13); exp_q.push_back(-32'sd50);
        recv_results(0);
    endtask

    task automatic test_backpressure();
        int v0, m0;
        v0 = viol_cnt;
        m0 = mv_cnt;
        send_frame(64'h0706050403010002, 3);
        exp_q.push_back(32'd8);  exp_q.push_back(32'd10);
        exp_q.push_back(32'd22); exp_q.push_back(32'd26);
        recv_results(5);
        checks++;
        if (viol_cnt !== v0) begin
            failures++;
            $display("FAIL bp_ready_while_busy: got %0d cycles required 0", viol_cnt - v0);
        end
        checks++;
        if (mv_cnt - m0 !== 24) begin
            failures++;
            $display("FAIL bp_valid_cycles: got %0d required 24", mv_cnt - m0);
        end
    endtask

    task automatic test_frame_error();
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) send_beat(8'(i + 1), (i == 3), 0);
        repeat (2) @(negedge clk);
        checks++;
        if (err_frame !== 1'b1 || start_cnt !== s0 || dbg_state !== S_LOAD || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_error: err=%b starts=%0d state=%0d rdy=%b required 1 0 0 1",
                     err_frame, start_cnt - s0, dbg_state, s_ready);
        end
        send_frame(64'h0807060504030201, 0);
        exp_q.push_back(32'd19); exp_q.push_back(32'd22);
        exp_q.push_back(32'd43); exp_q.push_back(32'd50);
        recv_results(0);
        checks++;
        if (err_frame !== 1'b1 || start_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL frame_sticky: err=%b starts=%0d required 1 1", err_frame, start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int m0;
        core_en = 1'b0;
        m0 = mv_cnt;
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pre: err_timeout=%b required 0", err_timeout);
        end
        send_frame(64'h0807060504030201, 0);
        repeat (TO_CYC) @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || dbg_state !== S_WAIT) begin
            failures++;
            $display("FAIL timeout_early: err_timeout=%b state=%0d required 0 2", err_timeout, dbg_state);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || s_ready !== 1'b1 || dbg_state !== S_LOAD) begin
            failures++;
            $display("FAIL timeout_edge: err_timeout=%b rdy=%b state=%0d required 1 1 0", err_timeout, s_ready, dbg_state);
        end
        checks++;
        if (mv_cnt !== m0) begin
            failures++;
            $display("FAIL timeout_no_output: m_valid cycles=%0d required 0", mv_cnt - m0);
        end
    endtask

    task automatic test_reset_mid();
        int m0, s0;
        core_en = 1'b0;
        send_frame(64'h0807060504030201, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== S_WAIT) begin
            failures++;
            $display("FAIL rmid_in_wait: state=%0d required 2", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rmid_reset");
        rst = 1'b0;
        m0 = mv_cnt;
        s0 = start_cnt;
        manual_req++;
        repeat (6) @(negedge clk);
        checks++;
        if (mv_cnt !== m0 || start_cnt !== s0 || dbg_state !== S_LOAD || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_stray_done: mv=%0d starts=%0d state=%0d rdy=%b required 0 0 0 1",
                     mv_cnt - m0, start_cnt - s0, dbg_state, s_ready);
        end
        core_en = 1'b1;
        send_frame(64'h0807060504030201, 0);
        exp_q.push_back(32'd19); exp_q.push_back(32'd22);
        exp_q.push_back(32'd43); exp_q.push_back(32'd50);
        recv_results(0);
        checks++;
        if (err_frame !== 1'b0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rmid_errs_cleared: ef=%b et=%b required 0 0", err_frame, err_timeout);
        end
    endtask

    // Global time bound
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_frame_error();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
